free_list: RTL and testbench

Physical-register free list for the rename stage. Supplies up to two unused physical register tags per cycle to rename/dispatch, and receives the previous mapping (`rd_phy_old_commit`) from the reorder buffer's retire port. Implemented as a circular FIFO plus a per-tag "free" bitmap that detects double frees.

---
 rtl/free_list.sv | 120 ++++++++++++
 tb/tb_free_list.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// rtl/free_list.sv - physical-register free list: circular tag FIFO plus per-tag free bitmap
module free_list #(
  parameter int NUM_PHY_REGS  = 64,
  parameter int NUM_ARCH_REGS = 32,
  parameter int PHY_WIDTH     = 6,
  parameter int FL_DEPTH      = NUM_PHY_REGS - NUM_ARCH_REGS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 alloc_req,
  output logic                       alloc_ready,
  output logic [PHY_WIDTH-1:0]       alloc_phy_0,
  output logic [PHY_WIDTH-1:0]       alloc_phy_1,
  input  logic                       retire_valid,
  input  logic [4:0]                 rd_arch_commit,
  input  logic [PHY_WIDTH-1:0]       rd_phy_old_commit,
  output logic [$clog2(FL_DEPTH):0]  free_count,
  output logic                       free_error
);

  localparam int PTR_W = $clog2(FL_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FL_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FL_DEPTH);

  logic [PHY_WIDTH-1:0]    fifo_q [FL_DEPTH];
  logic [PHY_WIDTH-1:0]    fifo_d [FL_DEPTH];
  logic [PTR_W-1:0]        head_q, head_d;
  logic [PTR_W-1:0]        tail_q, tail_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [NUM_PHY_REGS-1:0] free_map_q, free_map_d;
  logic                    free_error_q, free_error_d;

  logic [CNT_W-1:0]        n_req;
  logic [CNT_W-1:0]        pops;
  logic [PTR_W-1:0]        head_nxt;
  logic                    push_try;
  logic                    push_ok;

  // Pointer advance that wraps at the last FIFO slot (depth need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign free_count = count_q;
  assign free_error = free_error_q;

  // Grant decision and tag selection; all-or-nothing, driven from current count only.
  always_comb begin
    n_req       = CNT_W'(alloc_req[0]) + CNT_W'(alloc_req[1]);
    head_nxt    = ptr_inc(head_q);
    alloc_ready = (count_q >= n_req);
    pops        = alloc_ready ? n_req : '0;
    alloc_phy_0 = '0;
    alloc_phy_1 = '0;
    if (alloc_ready) begin
      if (alloc_req[0]) alloc_phy_0 = fifo_q[head_q];
      if (alloc_req[1]) alloc_phy_1 = alloc_req[0] ? fifo_q[head_nxt] : fifo_q[head_q];
    end
  end

  // Push acceptance: tag 0 is never a free-list tag, double frees and overflow are rejected.
  always_comb begin
    push_try = retire_valid && (rd_arch_commit != '0);
    push_ok  = push_try
            && (rd_phy_old_commit != '0)
            && !free_map_q[rd_phy_old_commit]
            && ((count_q - pops) < DEPTH_C);
  end

  // Next-state for FIFO, pointers, count and bitmap; push and pop apply together.
  always_comb begin
    fifo_d       = fifo_q;
    head_d       = head_q;
    tail_d       = tail_q;
    free_map_d   = free_map_q;
    free_error_d = push_try && !push_ok;
    count_d      = count_q - pops + CNT_W'(push_ok);

    case (pops)
      CNT_W'(1): head_d = head_nxt;
      CNT_W'(2): head_d = ptr_inc(head_nxt);
      default:   head_d = head_q;
    endcase

    // A popped tag always has its bit set, a pushed tag always has it clear, so they never collide.
    if (alloc_ready && alloc_req[0]) free_map_d[alloc_phy_0] = 1'b0;
    if (alloc_ready && alloc_req[1]) free_map_d[alloc_phy_1] = 1'b0;

    if (push_ok) begin
      fifo_d[tail_q]                = rd_phy_old_commit;
      tail_d                        = ptr_inc(tail_q);
      free_map_d[rd_phy_old_commit] = 1'b1;
    end
  end

  // State registers; reset loads the identity mapping's complement into the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        fifo_q[i] <= PHY_WIDTH'(NUM_ARCH_REGS + i);
      end
      for (int i = 0; i < NUM_PHY_REGS; i++) begin
        free_map_q[i] <= (i >= NUM_ARCH_REGS);
      end
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= DEPTH_C;
      free_error_q <= 1'b0;
    end else begin
      fifo_q       <= fifo_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      free_map_q   <= free_map_d;
      free_error_q <= free_error_d;
    end
  end

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - directed self-checking bench for free_list
module tb_free_list;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] alloc_req;
  logic       alloc_ready;
  logic [5:0] alloc_phy_0;
  logic [5:0] alloc_phy_1;
  logic       retire_valid;
  logic [4:0] rd_arch_commit;
  logic [5:0] rd_phy_old_commit;
  logic [5:0] free_count;
  logic       free_error;

  int checks = 0;
  int errors = 0;

  free_list dut (
    .clk               (clk),
    .rst               (rst),
    .alloc_req         (alloc_req),
    .alloc_ready       (alloc_ready),
    .alloc_phy_0       (alloc_phy_0),
    .alloc_phy_1       (alloc_phy_1),
    .retire_valid      (retire_valid),
    .rd_arch_commit    (rd_arch_commit),
    .rd_phy_old_commit (rd_phy_old_commit),
    .free_count        (free_count),
    .free_error        (free_error)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    alloc_req         = 2'b00;
    retire_valid      = 1'b0;
    rd_arch_commit    = 5'd0;
    rd_phy_old_commit = 6'd0;
  endtask

  task automatic drive_retire(input logic [4:0] arch, input logic [5:0] phy);
    retire_valid      = 1'b1;
    rd_arch_commit    = arch;
    rd_phy_old_commit = phy;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    #1;
    if (free_count !== 6'd32) begin $display("FAIL reset_free_count got %0d want 32", free_count); errors++; end checks++;
    if (free_error !== 1'b0) begin $display("FAIL reset_free_error got %0b want 0", free_error); errors++; end checks++;
    if (alloc_ready !== 1'b1) begin $display("FAIL reset_ready_idle got %0b want 1", alloc_ready); errors++; end checks++;
    if (alloc_phy_0 !== 6'd0) begin $display("FAIL reset_phy0_idle got %0d want 0", alloc_phy_0); errors++; end checks++;
    alloc_req = 2'b11;
    #1;
    if (alloc_phy_0 !== 6'd32) begin $display("FAIL reset_phy0_dual got %0d want 32", alloc_phy_0); errors++; end checks++;
    if (alloc_phy_1 !== 6'd33) begin $display("FAIL reset_phy1_dual got %0d want 33", alloc_phy_1); errors++; end checks++;
    alloc_req = 2'b00;
    rst = 1'b0;
  endtask

  task automatic test_single_alloc();
    @(negedge clk);
    alloc_req = 2'b01;
    #1;
    if (alloc_ready !== 1'b1) begin $display("FAIL single_ready got %0b want 1", alloc_ready); errors++; end checks++;
    if (alloc_phy_0 !== 6'd32) begin $display("FAIL single_phy0 got %0d want 32", alloc_phy_0); errors++; end checks++;
    if (alloc_phy_1 !== 6'd0) begin $display("FAIL single_phy1_zero got %0d want 0", alloc_phy_1); errors++; end checks++;
    @(negedge clk);
    alloc_req = 2'b10;
    #1;
    if (alloc_phy_1 !== 6'd33) begin $display("FAIL single_slot1_phy1 got %0d want 33", alloc_phy_1); errors++; end checks++;
    if (alloc_phy_0 !== 6'd0) begin $display("FAIL single_slot1_phy0 got %0d want 0", alloc_phy_0); errors++; end checks++;
    if (free_count !== 6'd31) begin $display("FAIL single_count_31 got %0d want 31", free_count); errors++; end checks++;
    @(negedge clk);
    alloc_req = 2'b00;
    #1;
    if (free_count !== 6'd30) begin $display("FAIL single_count_30 got %0d want 30", free_count); errors++; end checks++;
  endtask

  task automatic test_dual_to_empty();
    apply_reset();
    for (int k = 0; k < 16; k++) begin
      int exp0;
      int exp1;
      exp0 = 32 + 2 * k;
      exp1 = 33 + 2 * k;
      if (k != 0) @(negedge clk);
      alloc_req = 2'b11;
      #1;
      if (alloc_ready !== 1'b1) begin $display("FAIL dual_ready pair %0d got %0b want 1", k, alloc_ready); errors++; end checks++;
      if (alloc_phy_0 !== 6'(exp0)) begin $display("FAIL dual_phy0 pair %0d got %0d want %0d", k, alloc_phy_0, exp0); errors++; end checks++;
      if (alloc_phy_1 !== 6'(exp1)) begin $display("FAIL dual_phy1 pair %0d got %0d want %0d", k, alloc_phy_1, exp1); errors++; end checks++;
    end
    @(negedge clk);
    alloc_req = 2'b11;
    #1;
    if (free_count !== 6'd0) begin $display("FAIL empty_count got %0d want 0", free_count); errors++; end checks++;
    if (alloc_ready !== 1'b0) begin $display("FAIL empty_ready got %0b want 0", alloc_ready); errors++; end checks++;
    if (alloc_phy_0 !== 6'd0) begin $display("FAIL empty_phy0 got %0d want 0", alloc_phy_0); errors++; end checks++;
    if (alloc_phy_1 !== 6'd0) begin $display("FAIL empty_phy1 got %0d want 0", alloc_phy_1); errors++; end checks++;
    @(negedge clk);
    alloc_req = 2'b01;
    #1;
    if (free_count !== 6'd0) begin $display("FAIL empty_refused_count got %0d want 0", free_count); errors++; end checks++;
    if (alloc_ready !== 1'b0) begin $display("FAIL empty_single_ready got %0b want 0", alloc_ready); errors++; end checks++;
    @(negedge clk);
    alloc_req = 2'b00;
  endtask

  task automatic test_free_wrap();
    @(negedge clk);
    drive_retire(5'd5, 6'd7);
    alloc_req = 2'b01;
    #1;
    if (alloc_ready !== 1'b0) begin $display("FAIL wrap_no_bypass_ready got %0b want 0", alloc_ready); errors++; end checks++;
    if (alloc_phy_0 !== 6'd0) begin $display("FAIL wrap_no_bypass_phy0 got %0d want 0", alloc_phy_0); errors++; end checks++;
    @(negedge clk);
    idle_inputs();
    alloc_req = 2'b01;
    #1;
    if (free_count !== 6'd1) begin $display("FAIL wrap_count_1 got %0d want 1", free_count); errors++; end checks++;
    if (alloc_ready !== 1'b1) begin $display("FAIL wrap_ready got %0b want 1", alloc_ready); errors++; end checks++;
    if (alloc_phy_0 !== 6'd7) begin $display("FAIL wrap_phy0 got %0d want 7", alloc_phy_0); errors++; end checks++;
    if (free_error !== 1'b0) begin $display("FAIL wrap_no_error got %0b want 0", free_error); errors++; end checks++;
    @(negedge clk);
    alloc_req = 2'b00;
    #1;
    if (free_count !== 6'd0) begin $display("FAIL wrap_count_0 got %0d want 0", free_count); errors++; end checks++;
  endtask

  task automatic test_push_pop();
    @(negedge clk);
    drive_retire(5'd1, 6'd10);
    @(negedge clk);
    drive_retire(5'd2, 6'd11);
    @(negedge clk);
    drive_retire(5'd3, 6'd40);
    alloc_req = 2'b11;
    #1;
    if (free_count !== 6'd2) begin $display("FAIL pp_count_2 got %0d want 2", free_count); errors++; end checks++;
    if (alloc_ready !== 1'b1) begin $display("FAIL pp_ready got %0b want 1", alloc_ready); errors++; end checks++;
    if (alloc_phy_0 !== 6'd10) begin $display("FAIL pp_phy0 got %0d want 10", alloc_phy_0); errors++; end checks++;
    if (alloc_phy_1 !== 6'd11) begin $display("FAIL pp_phy1 got %0d want 11", alloc_phy_1); errors++; end checks++;
    @(negedge clk);
    idle_inputs();
    alloc_req = 2'b01;
    #1;
    if (free_count !== 6'd1) begin $display("FAIL pp_count_1 got %0d want 1", free_count); errors++; end checks++;
    if (alloc_phy_0 !== 6'd40) begin $display("FAIL pp_phy0_40 got %0d want 40", alloc_phy_0); errors++; end checks++;
    if (free_error !== 1'b0) begin $display("FAIL pp_no_error got %0b want 0", free_error); errors++; end checks++;
    @(negedge clk);
    alloc_req = 2'b00;
    #1;
    if (free_count !== 6'd0) begin $display("FAIL pp_count_0 got %0d want 0", free_count); errors++; end checks++;
  endtask

  task automatic test_errors();
    @(negedge clk);
    drive_retire(5'd4, 6'd45);
    @(negedge clk);
    drive_retire(5'd4, 6'd45);
    #1;
    if (free_count !== 6'd1) begin $display("FAIL err_first_push_count got %0d want 1", free_count); errors++; end checks++;
    if (free_error !== 1'b0) begin $display("FAIL err_first_push_error got %0b want 0", free_error); errors++; end checks++;
    @(negedge clk);
    drive_retire(5'd0, 6'd20);
    #1;
    if (free_error !== 1'b1) begin $display("FAIL err_double_free got %0b want 1", free_error); errors++; end checks++;
    if (free_count !== 6'd1) begin $display("FAIL err_double_count got %0d want 1", free_count); errors++; end checks++;
    @(negedge clk);
    drive_retire(5'd6, 6'd0);
    #1;
    if (free_error !== 1'b0) begin $display("FAIL err_arch0_silent got %0b want 0", free_error); errors++; end checks++;
    if (free_count !== 6'd1) begin $display("FAIL err_arch0_count got %0d want 1", free_count); errors++; end checks++;
    @(negedge clk);
    idle_inputs();
    #1;
    if (free_error !== 1'b1) begin $display("FAIL err_tag0 got %0b want 1", free_error); errors++; end checks++;
    if (free_count !== 6'd1) begin $display("FAIL err_tag0_count got %0d want 1", free_count); errors++; end checks++;
    @(negedge clk);
    #1;
    if (free_error !== 1'b0) begin $display("FAIL err_pulse_end got %0b want 0", free_error); errors++; end checks++;
  endtask

  task automatic test_overflow();
    apply_reset();
    drive_retire(5'd1, 6'd5);
    @(negedge clk);
    drive_retire(5'd1, 6'd5);
    alloc_req = 2'b01;
    #1;
    if (free_error !== 1'b1) begin $display("FAIL ovf_error got %0b want 1", free_error); errors++; end checks++;
    if (free_count !== 6'd32) begin $display("FAIL ovf_count got %0d want 32", free_count); errors++; end checks++;
    if (alloc_phy_0 !== 6'd32) begin $display("FAIL ovf_phy0 got %0d want 32", alloc_phy_0); errors++; end checks++;
    @(negedge clk);
    idle_inputs();
    #1;
    if (free_error !== 1'b0) begin $display("FAIL ovf_pop_push_error got %0b want 0", free_error); errors++; end checks++;
    if (free_count !== 6'd32) begin $display("FAIL ovf_pop_push_count got %0d want 32", free_count); errors++; end checks++;
  endtask

  task automatic test_mid_reset();
    apply_reset();
    alloc_req = 2'b11;
    #1;
    if (alloc_phy_0 !== 6'd32) begin $display("FAIL mr_first_phy0 got %0d want 32", alloc_phy_0); errors++; end checks++;
    @(negedge clk);
    alloc_req = 2'b11;
    #1;
    if (alloc_phy_0 !== 6'd34) begin $display("FAIL mr_second_phy0 got %0d want 34", alloc_phy_0); errors++; end checks++;
    if (alloc_phy_1 !== 6'd35) begin $display("FAIL mr_second_phy1 got %0d want 35", alloc_phy_1); errors++; end checks++;
    if (free_count !== 6'd30) begin $display("FAIL mr_count_30 got %0d want 30", free_count); errors++; end checks++;
    #2;
    rst = 1'b1;
    #1;
    if (free_count !== 6'd32) begin $display("FAIL mr_async_count got %0d want 32", free_count); errors++; end checks++;
    if (alloc_phy_0 !== 6'd32) begin $display("FAIL mr_async_phy0 got %0d want 32", alloc_phy_0); errors++; end checks++;
    if (alloc_phy_1 !== 6'd33) begin $display("FAIL mr_async_phy1 got %0d want 33", alloc_phy_1); errors++; end checks++;
    if (free_error !== 1'b0) begin $display("FAIL mr_async_error got %0b want 0", free_error); errors++; end checks++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    if (free_count !== 6'd32) begin $display("FAIL mr_held_count got %0d want 32", free_count); errors++; end checks++;
    if (alloc_phy_0 !== 6'd32) begin $display("FAIL mr_next_phy0 got %0d want 32", alloc_phy_0); errors++; end checks++;
    if (alloc_phy_1 !== 6'd33) begin $display("FAIL mr_next_phy1 got %0d want 33", alloc_phy_1); errors++; end checks++;
    @(negedge clk);
    alloc_req = 2'b00;
    #1;
    if (free_count !== 6'd30) begin $display("FAIL mr_after_count got %0d want 30", free_count); errors++; end checks++;
  endtask

  initial begin
    test_reset();
    test_single_alloc();
    test_dual_to_empty();
    test_free_wrap();
    test_push_pop();
    test_errors();
    test_overflow();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
